// File: rtl/icb_timer_pkg.sv
// Shared definitions for the ICB timer: bus widths, register offsets,
// CTRL bit positions and the write-strobe bundle passed to the core.
package icb_timer_pkg;

  localparam int MemAddrBus = 32;
  localparam int MemBus     = 32;

  // Byte offsets of the registers; only bits [4:2] are decoded.
  localparam logic [4:0] TMR_CTRL   = 5'h00;
  localparam logic [4:0] TMR_PRESC  = 5'h04;
  localparam logic [4:0] TMR_CNT_LO = 5'h08;
  localparam logic [4:0] TMR_CNT_HI = 5'h0C;
  localparam logic [4:0] TMR_CMP_LO = 5'h10;
  localparam logic [4:0] TMR_CMP_HI = 5'h14;
  localparam logic [4:0] TMR_STATUS = 5'h18;
  localparam logic [4:0] TMR_RSVD   = 5'h1C;

  // CTRL bit indices.
  localparam int CTRL_EN  = 0;
  localparam int CTRL_IE  = 1;
  localparam int CTRL_COM = 2;
  localparam int CTRL_W   = 3;

  // One strobe per writable register, asserted for a single accepted write.
  typedef struct packed {
    logic ctrl;
    logic presc;
    logic cnt_lo;
    logic cnt_hi;
    logic cmp_lo;
    logic cmp_hi;
    logic status;
  } tmr_we_t;

  // Byte-lane merge of a 32-bit register word with new write data.
  function automatic logic [MemBus-1:0] merge_word(input logic [MemBus-1:0] old_val,
                                                   input logic [MemBus-1:0] new_val,
                                                   input logic [MemBus-1:0] bit_mask);
    return (old_val & ~bit_mask) | (new_val & bit_mask);
  endfunction

endpackage

// File: rtl/icb_timer_if.sv
// ICB command/response channel between a bridge master port and the timer.
interface icb_timer_if;
  import icb_timer_pkg::*;

  logic                  tmr_icb_cmd_valid;
  logic                  tmr_icb_cmd_ready;
  logic [MemAddrBus-1:0] tmr_icb_cmd_addr;
  logic                  tmr_icb_cmd_read;
  logic [MemBus-1:0]     tmr_icb_cmd_wdata;
  logic [MemBus/8-1:0]   tmr_icb_cmd_wmask;
  logic                  tmr_icb_rsp_valid;
  logic                  tmr_icb_rsp_ready;
  logic                  tmr_icb_rsp_err;
  logic [MemBus-1:0]     tmr_icb_rsp_rdata;

  modport master (
    output tmr_icb_cmd_valid, tmr_icb_cmd_addr, tmr_icb_cmd_read,
           tmr_icb_cmd_wdata, tmr_icb_cmd_wmask, tmr_icb_rsp_ready,
    input  tmr_icb_cmd_ready, tmr_icb_rsp_valid, tmr_icb_rsp_err,
           tmr_icb_rsp_rdata
  );

  modport slave (
    input  tmr_icb_cmd_valid, tmr_icb_cmd_addr, tmr_icb_cmd_read,
           tmr_icb_cmd_wdata, tmr_icb_cmd_wmask, tmr_icb_rsp_ready,
    output tmr_icb_cmd_ready, tmr_icb_rsp_valid, tmr_icb_rsp_err,
           tmr_icb_rsp_rdata
  );

endinterface

// File: rtl/icb_timer_core.sv
// Timer datapath: CTRL/PRESC registers, prescaler, 64-bit counter,
// 64-bit compare and sticky match flag. Writes arrive as decoded strobes
// plus raw data and an expanded per-bit lane mask.
module icb_timer_core
  import icb_timer_pkg::*;
#(
  parameter int          PRESC_W = 16,
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               halt_i,
  input  tmr_we_t            i_we,
  input  logic [MemBus-1:0]  i_wdata,
  input  logic [MemBus-1:0]  i_bmask,
  output logic [CTRL_W-1:0]  o_ctrl,
  output logic [PRESC_W-1:0] o_presc,
  output logic [63:0]        o_cnt,
  output logic [63:0]        o_cmp,
  output logic               o_flag
);

  logic [CTRL_W-1:0]  r_ctrl,  w_ctrl_next;
  logic [PRESC_W-1:0] r_presc, w_presc_next;
  logic [PRESC_W-1:0] r_pcnt,  w_pcnt_next;
  logic [63:0]        r_cnt,   w_cnt_next;
  logic [63:0]        r_cmp,   w_cmp_next;
  logic               r_flag,  w_flag_next;

  logic w_en;
  logic w_match;
  logic w_tick;
  logic w_w1c;

  assign w_en    = r_ctrl[CTRL_EN];
  assign w_match = (r_cnt == r_cmp);
  assign w_tick  = w_en & ~halt_i & (r_pcnt == r_presc);
  assign w_w1c   = i_we.status & i_wdata[0] & i_bmask[0];

  // Next-state for every timer register; software writes are applied last
  // so they override a same-cycle hardware update of the counter.
  always_comb begin
    w_ctrl_next  = r_ctrl;
    w_presc_next = r_presc;
    w_pcnt_next  = r_pcnt;
    w_cnt_next   = r_cnt;
    w_cmp_next   = r_cmp;

    if (i_we.ctrl)
      w_ctrl_next = (r_ctrl & ~i_bmask[CTRL_W-1:0]) | (i_wdata[CTRL_W-1:0] & i_bmask[CTRL_W-1:0]);
    if (i_we.presc)
      w_presc_next = (r_presc & ~i_bmask[PRESC_W-1:0]) | (i_wdata[PRESC_W-1:0] & i_bmask[PRESC_W-1:0]);

    if (!w_en)
      w_pcnt_next = '0;
    else if (!halt_i)
      w_pcnt_next = (r_pcnt == r_presc) ? '0 : r_pcnt + 1'b1;

    if (w_tick)
      w_cnt_next = (r_ctrl[CTRL_COM] && w_match) ? 64'd0 : r_cnt + 64'd1;
    if (i_we.cnt_lo)
      w_cnt_next = {r_cnt[63:32], merge_word(r_cnt[31:0], i_wdata, i_bmask)};
    if (i_we.cnt_hi)
      w_cnt_next = {merge_word(r_cnt[63:32], i_wdata, i_bmask), r_cnt[31:0]};

    if (i_we.cmp_lo)
      w_cmp_next = {r_cmp[63:32], merge_word(r_cmp[31:0], i_wdata, i_bmask)};
    if (i_we.cmp_hi)
      w_cmp_next = {merge_word(r_cmp[63:32], i_wdata, i_bmask), r_cmp[31:0]};

    // A live match wins over a same-cycle write-1-to-clear.
    w_flag_next = (w_en & w_match) | (r_flag & ~w_w1c);
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl  <= '0;
      r_presc <= '0;
      r_pcnt  <= '0;
      r_cnt   <= 64'd0;
      r_cmp   <= CMP_RST;
      r_flag  <= 1'b0;
    end else begin
      r_ctrl  <= w_ctrl_next;
      r_presc <= w_presc_next;
      r_pcnt  <= w_pcnt_next;
      r_cnt   <= w_cnt_next;
      r_cmp   <= w_cmp_next;
      r_flag  <= w_flag_next;
    end
  end

  assign o_ctrl  = r_ctrl;
  assign o_presc = r_presc;
  assign o_cnt   = r_cnt;
  assign o_cmp   = r_cmp;
  assign o_flag  = r_flag;

endmodule

// File: rtl/icb_timer.sv
// ICB timer peripheral: single-outstanding ICB responder front-end with
// address decode, read mux and CNT hi-shadow, wrapped around the timer core.
module icb_timer
  import icb_timer_pkg::*;
#(
  parameter int          PRESC_W = 16,
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       halt_i,
  icb_timer_if.slave tmr_icb,
  output logic       tmr_irq
);

  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic [MemBus-1:0]   r_rsp_rdata;
  logic [31:0]         r_hi_shadow;

  logic                w_cmd_ready;
  logic                w_accept;
  logic                w_rd;
  logic                w_wr;
  logic [2:0]          w_sel;
  logic                w_rsvd;
  logic [MemBus-1:0]   w_bmask;
  logic [MemBus-1:0]   w_rdata;
  tmr_we_t             w_we;
  logic                w_unused_addr;

  logic [CTRL_W-1:0]   w_ctrl;
  logic [PRESC_W-1:0]  w_presc;
  logic [63:0]         w_cnt;
  logic [63:0]         w_cmp;
  logic                w_flag;

  assign w_cmd_ready   = ~r_rsp_valid | tmr_icb.tmr_icb_rsp_ready;
  assign w_accept      = tmr_icb.tmr_icb_cmd_valid & w_cmd_ready;
  assign w_rd          = w_accept &  tmr_icb.tmr_icb_cmd_read;
  assign w_wr          = w_accept & ~tmr_icb.tmr_icb_cmd_read;
  assign w_sel         = tmr_icb.tmr_icb_cmd_addr[4:2];
  assign w_rsvd        = (w_sel == TMR_RSVD[4:2]);
  assign w_unused_addr = ^{tmr_icb.tmr_icb_cmd_addr[MemAddrBus-1:5], tmr_icb.tmr_icb_cmd_addr[1:0]};

  // Expand the byte-lane enables into a per-bit mask.
  generate
    for (genvar gi = 0; gi < MemBus / 8; gi++) begin : g_bmask
      assign w_bmask[gi*8 +: 8] = {8{tmr_icb.tmr_icb_cmd_wmask[gi]}};
    end
  endgenerate

  assign w_we.ctrl   = w_wr & (w_sel == TMR_CTRL[4:2]);
  assign w_we.presc  = w_wr & (w_sel == TMR_PRESC[4:2]);
  assign w_we.cnt_lo = w_wr & (w_sel == TMR_CNT_LO[4:2]);
  assign w_we.cnt_hi = w_wr & (w_sel == TMR_CNT_HI[4:2]);
  assign w_we.cmp_lo = w_wr & (w_sel == TMR_CMP_LO[4:2]);
  assign w_we.cmp_hi = w_wr & (w_sel == TMR_CMP_HI[4:2]);
  assign w_we.status = w_wr & (w_sel == TMR_STATUS[4:2]);

  icb_timer_core #(
    .PRESC_W (PRESC_W),
    .CMP_RST (CMP_RST)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .halt_i  (halt_i),
    .i_we    (w_we),
    .i_wdata (tmr_icb.tmr_icb_cmd_wdata),
    .i_bmask (w_bmask),
    .o_ctrl  (w_ctrl),
    .o_presc (w_presc),
    .o_cnt   (w_cnt),
    .o_cmp   (w_cmp),
    .o_flag  (w_flag)
  );

  // Read mux over the register values as they stand before this edge.
  always_comb begin
    w_rdata = '0;
    case (w_sel)
      TMR_CTRL[4:2]:   w_rdata = MemBus'(w_ctrl);
      TMR_PRESC[4:2]:  w_rdata = MemBus'(w_presc);
      TMR_CNT_LO[4:2]: w_rdata = w_cnt[31:0];
      TMR_CNT_HI[4:2]: w_rdata = r_hi_shadow;
      TMR_CMP_LO[4:2]: w_rdata = w_cmp[31:0];
      TMR_CMP_HI[4:2]: w_rdata = w_cmp[63:32];
      TMR_STATUS[4:2]: w_rdata = {{(MemBus-1){1'b0}}, w_flag};
      default:         w_rdata = '0;
    endcase
  end

  // Response channel: load on accept, retire on rsp_ready, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_rsvd;
      r_rsp_rdata <= (w_rd && !w_rsvd) ? w_rdata : '0;
    end else if (tmr_icb.tmr_icb_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Snapshot CNT[63:32] on a CNT_LO read so a following CNT_HI read is coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_hi_shadow <= '0;
    else if (w_rd && (w_sel == TMR_CNT_LO[4:2]))
      r_hi_shadow <= w_cnt[63:32];
  end

  assign tmr_icb.tmr_icb_cmd_ready = w_cmd_ready;
  assign tmr_icb.tmr_icb_rsp_valid = r_rsp_valid;
  assign tmr_icb.tmr_icb_rsp_err   = r_rsp_err;
  assign tmr_icb.tmr_icb_rsp_rdata = r_rsp_rdata;
  assign tmr_irq                   = w_flag & w_ctrl[CTRL_IE];

endmodule

// File: tb/tb_icb_timer.sv
// Directed testbench for icb_timer: register reset values, handshake and
// backpressure, lane-masked writes, timer run/match/clear, coherent 64-bit
// reads, debug halt, flag-set vs W1C priority and reset mid-transaction.
module tb_icb_timer;
  import icb_timer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halt_i = 1'b0;
  logic tmr_irq;

  icb_timer_if tmr_icb();

  icb_timer #(
    .PRESC_W (16),
    .CMP_RST (64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .halt_i  (halt_i),
    .tmr_icb (tmr_icb),
    .tmr_irq (tmr_irq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One ICB transaction with rsp_ready held high; response expected one cycle after accept.
  task automatic icb_xfer(input logic [4:0] a, input logic rd, input logic [31:0] wd,
                          input logic [3:0] wm, output logic [31:0] rdat, output logic err);
    int n;
    @(negedge clk);
    tmr_icb.tmr_icb_cmd_addr  = {27'd0, a};
    tmr_icb.tmr_icb_cmd_read  = rd;
    tmr_icb.tmr_icb_cmd_wdata = wd;
    tmr_icb.tmr_icb_cmd_wmask = wm;
    tmr_icb.tmr_icb_cmd_valid = 1'b1;
    tmr_icb.tmr_icb_rsp_ready = 1'b1;
    n = 0;
    while (!tmr_icb.tmr_icb_cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_val("cmd_ready_timeout", 64'(tmr_icb.tmr_icb_cmd_ready), 64'd1);
    @(negedge clk);
    tmr_icb.tmr_icb_cmd_valid = 1'b0;
    check_val("rsp_latency", 64'(tmr_icb.tmr_icb_rsp_valid), 64'd1);
    rdat = tmr_icb.tmr_icb_rsp_rdata;
    err  = tmr_icb.tmr_icb_rsp_err;
    $display("icb %s addr=0x%02h wdata=0x%08h wmask=%b -> rdata=0x%08h err=%0d",
             rd ? "RD" : "WR", a, wd, wm, rdat, err);
  endtask

  task automatic rd_val(input logic [4:0] a, output logic [31:0] v);
    logic e;
    icb_xfer(a, 1'b1, 32'd0, 4'h0, v, e);
  endtask

  task automatic rd_exp(input string tag, input logic [4:0] a, input logic [31:0] exp, input logic exp_err);
    logic [31:0] v;
    logic e;
    icb_xfer(a, 1'b1, 32'd0, 4'h0, v, e);
    check_val(tag, 64'(v), 64'(exp));
    check_val({tag, "_err"}, 64'(e), 64'(exp_err));
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] v;
    logic e;
    icb_xfer(a, 1'b0, d, m, v, e);
  endtask

  logic [31:0] rst_exp [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};

  initial begin
    logic [31:0] v, v1, v2, v3;
    logic e;
    bit found;

    tmr_icb.tmr_icb_cmd_valid = 1'b0;
    tmr_icb.tmr_icb_cmd_addr  = '0;
    tmr_icb.tmr_icb_cmd_read  = 1'b1;
    tmr_icb.tmr_icb_cmd_wdata = '0;
    tmr_icb.tmr_icb_cmd_wmask = '0;
    tmr_icb.tmr_icb_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_rsp_valid", 64'(tmr_icb.tmr_icb_rsp_valid), 64'd0);
    check_val("rst_cmd_ready", 64'(tmr_icb.tmr_icb_cmd_ready), 64'd1);
    check_val("rst_irq", 64'(tmr_irq), 64'd0);
    rst_n = 1'b1;

    // Reset values of every register.
    for (int i = 0; i < 7; i++) rd_exp("rst_reg", 5'(i * 4), rst_exp[i], 1'b0);

    // Reserved offset: error on read and write, no side effect.
    rd_exp("rsvd_rd", TMR_RSVD, 32'h0, 1'b1);
    icb_xfer(TMR_RSVD, 1'b0, 32'hFFFF_FFFF, 4'hF, v, e);
    check_val("rsvd_wr_err", 64'(e), 64'd1);
    rd_exp("ctrl_after_rsvd", TMR_CTRL, 32'h0, 1'b0);

    // Lane-masked write touches only byte 1.
    wr(TMR_CMP_LO, 32'hAABB_CCDD, 4'b0010);
    rd_exp("cmp_lo_mask", TMR_CMP_LO, 32'hFFFF_CCFF, 1'b0);

    // Backpressure: response held for 5 cycles, then a queued command is taken the same cycle.
    @(negedge clk);
    tmr_icb.tmr_icb_cmd_addr  = {27'd0, TMR_CMP_LO};
    tmr_icb.tmr_icb_cmd_read  = 1'b1;
    tmr_icb.tmr_icb_cmd_valid = 1'b1;
    tmr_icb.tmr_icb_rsp_ready = 1'b0;
    @(negedge clk);
    tmr_icb.tmr_icb_cmd_addr  = {27'd0, TMR_CTRL};
    for (int i = 0; i < 5; i++) begin
      check_val("bp_rsp_valid", 64'(tmr_icb.tmr_icb_rsp_valid), 64'd1);
      check_val("bp_rdata", 64'(tmr_icb.tmr_icb_rsp_rdata), 64'hFFFF_CCFF);
      check_val("bp_cmd_ready", 64'(tmr_icb.tmr_icb_cmd_ready), 64'd0);
      @(negedge clk);
    end
    $display("icb RD addr=0x10 held 5 cycles -> rdata=0x%08h", tmr_icb.tmr_icb_rsp_rdata);
    tmr_icb.tmr_icb_rsp_ready = 1'b1;
    #1;
    check_val("bp_release_ready", 64'(tmr_icb.tmr_icb_cmd_ready), 64'd1);
    @(negedge clk);
    tmr_icb.tmr_icb_cmd_valid = 1'b0;
    check_val("bp_next_valid", 64'(tmr_icb.tmr_icb_rsp_valid), 64'd1);
    check_val("bp_next_rdata", 64'(tmr_icb.tmr_icb_rsp_rdata), 64'h0);
    $display("icb RD addr=0x00 back-to-back -> rdata=0x%08h", tmr_icb.tmr_icb_rsp_rdata);
    @(negedge clk);
    check_val("bp_drop_valid", 64'(tmr_icb.tmr_icb_rsp_valid), 64'd0);

    // Coherent 64-bit read across a carry into CNT[63:32].
    wr(TMR_PRESC, 32'd0, 4'hF);
    wr(TMR_CNT_LO, 32'hFFFF_FFFE, 4'hF);
    wr(TMR_CNT_HI, 32'h1, 4'hF);
    wr(TMR_CTRL, 32'h1, 4'hF);
    rd_exp("atomic_lo", TMR_CNT_LO, 32'hFFFF_FFFF, 1'b0);
    rd_exp("atomic_hi", TMR_CNT_HI, 32'h1, 1'b0);
    rd_val(TMR_CNT_LO, v);
    rd_exp("shadow_refresh", TMR_CNT_HI, 32'h2, 1'b0);
    wr(TMR_CTRL, 32'h0, 4'hF);

    // Timer run with clear-on-match: PRESC=3, CMP=10.
    wr(TMR_PRESC, 32'd3, 4'hF);
    wr(TMR_CMP_HI, 32'd0, 4'hF);
    wr(TMR_CMP_LO, 32'd10, 4'hF);
    wr(TMR_CNT_HI, 32'd0, 4'hF);
    wr(TMR_CNT_LO, 32'd0, 4'hF);
    rd_exp("status_before_run", TMR_STATUS, 32'h0, 1'b0);
    wr(TMR_CTRL, 32'h7, 4'hF);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      rd_val(TMR_STATUS, v);
      if (v[0]) found = 1'b1;
    end
    check_val("flag_seen", 64'(found), 64'd1);
    check_val("irq_on_match", 64'(tmr_irq), 64'd1);
    rd_val(TMR_CNT_LO, v);
    check_val("cnt_at_match", 64'(v == 32'd10 || v == 32'd0), 64'd1);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      rd_val(TMR_CNT_LO, v);
      if (v == 32'd0) found = 1'b1;
    end
    check_val("cnt_wrapped_to_0", 64'(found), 64'd1);
    wr(TMR_STATUS, 32'h1, 4'h1);
    rd_exp("status_w1c", TMR_STATUS, 32'h0, 1'b0);
    check_val("irq_cleared", 64'(tmr_irq), 64'd0);

    // Debug halt freezes the counter while the bus stays live.
    @(negedge clk);
    halt_i = 1'b1;
    rd_val(TMR_CNT_LO, v1);
    repeat (20) @(negedge clk);
    rd_val(TMR_CNT_LO, v2);
    check_val("halt_cnt_frozen", 64'(v2), 64'(v1));
    halt_i = 1'b0;
    repeat (8) @(negedge clk);
    rd_val(TMR_CNT_LO, v3);
    check_val("run_after_halt", 64'(v3 != v1), 64'd1);

    // Match held every cycle (no tick): W1C cannot clear the flag.
    wr(TMR_CTRL, 32'h0, 4'hF);
    wr(TMR_PRESC, 32'h0000_FFFF, 4'hF);
    wr(TMR_CMP_LO, 32'd5, 4'hF);
    wr(TMR_CNT_HI, 32'd0, 4'hF);
    wr(TMR_CNT_LO, 32'd5, 4'hF);
    wr(TMR_STATUS, 32'h1, 4'h1);
    rd_exp("status_idle", TMR_STATUS, 32'h0, 1'b0);
    wr(TMR_CTRL, 32'h3, 4'hF);
    wr(TMR_STATUS, 32'h1, 4'h1);
    rd_exp("flag_beats_w1c", TMR_STATUS, 32'h1, 1'b0);
    check_val("irq_held", 64'(tmr_irq), 64'd1);
    wr(TMR_CMP_LO, 32'd6, 4'hF);
    wr(TMR_STATUS, 32'h1, 4'h1);
    rd_exp("w1c_no_match", TMR_STATUS, 32'h0, 1'b0);
    check_val("irq_off", 64'(tmr_irq), 64'd0);

    // Reset while a response is pending drops it immediately.
    @(negedge clk);
    tmr_icb.tmr_icb_cmd_addr  = {27'd0, TMR_CTRL};
    tmr_icb.tmr_icb_cmd_read  = 1'b1;
    tmr_icb.tmr_icb_cmd_valid = 1'b1;
    tmr_icb.tmr_icb_rsp_ready = 1'b0;
    @(negedge clk);
    tmr_icb.tmr_icb_cmd_valid = 1'b0;
    check_val("pending_before_rst", 64'(tmr_icb.tmr_icb_rsp_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_drops_rsp", 64'(tmr_icb.tmr_icb_rsp_valid), 64'd0);
    $display("icb RD addr=0x00 pending, reset asserted -> rsp_valid=%0d", tmr_icb.tmr_icb_rsp_valid);
    @(negedge clk);
    rst_n = 1'b1;
    tmr_icb.tmr_icb_rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_val("no_rsp_after_rst", 64'(tmr_icb.tmr_icb_rsp_valid), 64'd0);
    rd_exp("cmp_lo_after_rst", TMR_CMP_LO, 32'hFFFF_FFFF, 1'b0);
    rd_exp("ctrl_after_rst", TMR_CTRL, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
